// File: rtl/usr_pkg.sv
// Shared mode encodings, FSM state type and burst-eligibility helper for
// the parametrised universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTR = 3'b100;
    localparam logic [2:0] MODE_ROTL = 3'b101;
    localparam logic [2:0] MODE_SSHL = 3'b110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic logic is_burstable(input logic [2:0] mode);
        return (mode == MODE_SHR)  || (mode == MODE_SHL)  ||
               (mode == MODE_ROTR) || (mode == MODE_ROTL) ||
               (mode == MODE_SSHL);
    endfunction

endpackage

// File: rtl/usr_next_value.sv
// Combinational next-state selector for the shift register contents.
// The reserved encoding falls through to hold.
module usr_next_value
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             right_in,
    input  logic             left_in,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        case (mode)
            MODE_SHR:  next_q = {q[WIDTH-2:0], right_in};
            MODE_SHL:  next_q = {left_in, q[WIDTH-1:1]};
            MODE_LOAD: next_q = data_in;
            MODE_ROTR: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTL: next_q = {q[0], q[WIDTH-1:1]};
            MODE_SSHL: next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   next_q = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_param.sv
// WIDTH-bit universal shift register with a burst sequencer that repeats a
// shift/rotate a latched number of times from a single start pulse.
module universal_shift_register_param
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             right_in,
    input  logic             left_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             right_out,
    output logic             left_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [2:0]       burst_mode;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] next_q;

    // During a burst the latched mode drives the shifter; live mode is ignored.
    assign op_mode = (state == ST_BURST) ? burst_mode : mode;

    usr_next_value #(
        .WIDTH (WIDTH)
    ) u_next (
        .q        (q),
        .mode     (op_mode),
        .data_in  (data_in),
        .right_in (right_in),
        .left_in  (left_in),
        .next_q   (next_q)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            q          <= '0;
            state      <= ST_IDLE;
            burst_mode <= MODE_HOLD;
            remaining  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_burstable(mode)) begin
                        // A zero-length burst completes immediately without touching q.
                        if (count != '0) begin
                            burst_mode <= mode;
                            remaining  <= count;
                            state      <= ST_BURST;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (enable) begin
                        q <= next_q;
                    end
                end
                ST_BURST: begin
                    if (enable) begin
                        q         <= next_q;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_BURST);
    assign right_out = q[WIDTH-1];
    assign left_out  = q[0];

endmodule

// File: tb/tb_universal_shift_register_param.sv
// Scoreboard bench: the driver queues hand-computed per-edge expectations and
// a monitor on the falling edge pops and compares them against the outputs.
module tb_universal_shift_register_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             clear;
    logic             enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             right_in;
    logic             left_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             right_out;
    logic             left_out;
    logic             busy;
    logic             done;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    universal_shift_register_param #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .enable    (enable),
        .mode      (mode),
        .data_in   (data_in),
        .right_in  (right_in),
        .left_in   (left_in),
        .start     (start),
        .count     (count),
        .q         (q),
        .right_out (right_out),
        .left_out  (left_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp_v);
        end
    endtask

    // Monitor: the DUT presents a result after every edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".q"},    q,                e.q);
                check({e.name, ".busy"}, {7'b0, busy},     {7'b0, e.busy});
                check({e.name, ".done"}, {7'b0, done},     {7'b0, e.done});
                check({e.name, ".rout"}, {7'b0, right_out}, {7'b0, e.q[7]});
                check({e.name, ".lout"}, {7'b0, left_out},  {7'b0, e.q[0]});
                check({e.name, ".excl"}, {7'b0, busy & done}, 8'h00);
            end
        end
    end

    task automatic drive(input logic clr, input logic en, input logic [2:0] md,
                         input logic [7:0] d, input logic st, input logic [3:0] cnt);
        clear   = clr;
        enable  = en;
        mode    = md;
        data_in = d;
        start   = st;
        count   = cnt;
    endtask

    task automatic step(input logic [7:0] eq, input logic eb, input logic ed, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.q = eq; e.busy = eb; e.done = ed; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] v);
        drive(1'b0, 1'b1, 3'b011, v, 1'b0, 4'd0);
        step(v, 1'b0, 1'b0, "load");
    endtask

    initial begin
        int unsigned waited;
        right_in = 1'b0;
        left_in  = 1'b0;

        // Reset and load
        drive(1'b1, 1'b1, 3'b011, 8'h5A, 1'b0, 4'd0);
        step(8'h00, 1'b0, 1'b0, "rst0");
        step(8'h00, 1'b0, 1'b0, "rst1");
        load(8'hA5);
        drive(1'b0, 1'b0, 3'b011, 8'hFF, 1'b0, 4'd0);
        step(8'hA5, 1'b0, 1'b0, "en_hold");

        // Shifts from A5
        right_in = 1'b1;
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 4'd0);
        step(8'h4B, 1'b0, 1'b0, "shr");
        right_in = 1'b0;
        load(8'hA5);
        left_in = 1'b0;
        drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 4'd0);
        step(8'h52, 1'b0, 1'b0, "shl");
        load(8'hA5);
        drive(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 4'd0);
        step(8'hA5, 1'b0, 1'b0, "rsvd");

        // Rotates and sign-preserving shift
        load(8'h81);
        drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 4'd0);
        step(8'h03, 1'b0, 1'b0, "rotr");
        load(8'h81);
        drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 4'd0);
        step(8'hC0, 1'b0, 1'b0, "rotl");
        load(8'h90);
        drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 4'd0);
        step(8'hC8, 1'b0, 1'b0, "sshl_neg");
        load(8'h7F);
        drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 4'd0);
        step(8'h3F, 1'b0, 1'b0, "sshl_pos");

        // Burst ROTR x3; live mode/data changed to show they are ignored
        load(8'h01);
        drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b1, 4'd3);
        step(8'h01, 1'b1, 1'b0, "b1_t0");
        drive(1'b0, 1'b1, 3'b011, 8'hFF, 1'b0, 4'd0);
        step(8'h02, 1'b1, 1'b0, "b1_s1");
        step(8'h04, 1'b1, 1'b0, "b1_s2");
        step(8'h08, 1'b0, 1'b1, "b1_s3");
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0);
        step(8'h08, 1'b0, 1'b0, "b1_after");

        // Same burst with a one-cycle stall
        load(8'h01);
        drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b1, 4'd3);
        step(8'h01, 1'b1, 1'b0, "b2_t0");
        drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 4'd0);
        step(8'h02, 1'b1, 1'b0, "b2_s1");
        enable = 1'b0;
        step(8'h02, 1'b1, 1'b0, "b2_stall");
        enable = 1'b1;
        step(8'h04, 1'b1, 1'b0, "b2_s2");
        step(8'h08, 1'b0, 1'b1, "b2_s3");

        // Zero-count start, with enable low
        drive(1'b0, 1'b0, 3'b100, 8'h00, 1'b1, 4'd0);
        step(8'h08, 1'b0, 1'b1, "cnt0_done");
        drive(1'b0, 1'b0, 3'b100, 8'h00, 1'b0, 4'd0);
        step(8'h08, 1'b0, 1'b0, "cnt0_after");

        // Start with a non-burstable mode is a plain load
        drive(1'b0, 1'b1, 3'b011, 8'h33, 1'b1, 4'd2);
        step(8'h33, 1'b0, 1'b0, "start_load");

        // ROTL x2 with start held during the burst, then back-to-back SHR x1
        drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b1, 4'd2);
        step(8'h33, 1'b1, 1'b0, "b3_t0");
        drive(1'b0, 1'b1, 3'b011, 8'hFF, 1'b1, 4'd7);
        step(8'h99, 1'b1, 1'b0, "b3_s1");
        drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b1, 4'd2);
        step(8'hCC, 1'b0, 1'b1, "b3_s2");
        right_in = 1'b0;
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 4'd1);
        step(8'hCC, 1'b1, 1'b0, "b4_t0");
        drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 4'd0);
        step(8'h98, 1'b0, 1'b1, "b4_s1");

        // Clear mid-burst
        load(8'h01);
        drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b1, 4'd5);
        step(8'h01, 1'b1, 1'b0, "b5_t0");
        drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 4'd0);
        step(8'h02, 1'b1, 1'b0, "b5_s1");
        step(8'h04, 1'b1, 1'b0, "b5_s2");
        clear = 1'b1;
        step(8'h00, 1'b0, 1'b0, "b5_clr");
        clear = 1'b0;
        step(8'h00, 1'b0, 1'b0, "b5_nodone");

        // Fresh burst from zero
        right_in = 1'b1;
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 4'd2);
        step(8'h00, 1'b1, 1'b0, "b6_t0");
        drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 4'd0);
        step(8'h01, 1'b1, 1'b0, "b6_s1");
        step(8'h03, 1'b0, 1'b1, "b6_s2");
        step(8'h03, 1'b0, 1'b0, "b6_after");

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
